// File: rtl/cic_decim_m5.sv
// Order-5 complex (I/Q) CIC decimator: five integrators per rail at the input
// strobe rate, then a pipelined 5-stage comb chain at clock rate.
// Ports: clock, reset_n (async, active-low); in_strobe, x_real, x_imag in;
//        out_strobe (1-cycle pulse), y_real, y_imag out (held between pulses).
// Option: define CIC_DECIM_ROUND_EN for round-half-up instead of truncation.
module cic_decim_m5 #(
    parameter int RATE  = 32,
    parameter int IBITS = 18,
    parameter int OBITS = 24,
    parameter int GBITS = 25
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    in_strobe,
    input  logic signed [IBITS-1:0] x_real,
    input  logic signed [IBITS-1:0] x_imag,
    output logic                    out_strobe,
    output logic signed [OBITS-1:0] y_real,
    output logic signed [OBITS-1:0] y_imag
);

    localparam int CBITS = IBITS + GBITS;
    localparam logic [15:0] LAST = 16'(RATE - 1);

`ifdef CIC_DECIM_ROUND_EN
    localparam logic signed [CBITS-1:0] HALF =
        {{(CBITS-1){1'b0}}, 1'b1} << (CBITS - OBITS - 1);
`endif

    logic signed [CBITS-1:0] ir_q [5];
    logic signed [CBITS-1:0] ir_d [5];
    logic signed [CBITS-1:0] ii_q [5];
    logic signed [CBITS-1:0] ii_d [5];
    logic signed [CBITS-1:0] cr_q [5];
    logic signed [CBITS-1:0] cr_d [5];
    logic signed [CBITS-1:0] ci_q [5];
    logic signed [CBITS-1:0] ci_d [5];
    logic signed [CBITS-1:0] dr_q [5];
    logic signed [CBITS-1:0] dr_d [5];
    logic signed [CBITS-1:0] di_q [5];
    logic signed [CBITS-1:0] di_d [5];

    logic [15:0]             cnt_q, cnt_d;
    logic [5:0]              v_q, v_d;
    logic                    out_strobe_q, out_strobe_d;
    logic signed [OBITS-1:0] y_real_q, y_real_d;
    logic signed [OBITS-1:0] y_imag_q, y_imag_d;

    logic signed [CBITS-1:0] xr_ext, xi_ext;
    logic                    evt;

    always_comb begin
        xr_ext = {{GBITS{x_real[IBITS-1]}}, x_real};
        xi_ext = {{GBITS{x_imag[IBITS-1]}}, x_imag};
        evt    = in_strobe && (cnt_q == LAST);

        ir_d = ir_q;
        ii_d = ii_q;
        cnt_d = cnt_q;
        if (in_strobe) begin
            // Each integrator adds the previous stage's registered value.
            ir_d[0] = ir_q[0] + xr_ext;
            ii_d[0] = ii_q[0] + xi_ext;
            for (int k = 1; k < 5; k++) begin
                ir_d[k] = ir_q[k] + ir_q[k-1];
                ii_d[k] = ii_q[k] + ii_q[k-1];
            end
            cnt_d = (cnt_q == LAST) ? 16'd0 : cnt_q + 16'd1;
        end

        cr_d = cr_q;
        ci_d = ci_q;
        dr_d = dr_q;
        di_d = di_q;
        if (v_q[0]) begin
            cr_d[0] = ir_q[4] - dr_q[0];
            ci_d[0] = ii_q[4] - di_q[0];
            dr_d[0] = ir_q[4];
            di_d[0] = ii_q[4];
        end
        for (int k = 1; k < 5; k++) begin
            if (v_q[k]) begin
                cr_d[k] = cr_q[k-1] - dr_q[k];
                ci_d[k] = ci_q[k-1] - di_q[k];
                dr_d[k] = cr_q[k-1];
                di_d[k] = ci_q[k-1];
            end
        end

        v_d          = {v_q[4:0], evt};
        out_strobe_d = v_q[5];
        y_real_d     = y_real_q;
        y_imag_d     = y_imag_q;
        if (v_q[5]) begin
`ifdef CIC_DECIM_ROUND_EN
            y_real_d = OBITS'((cr_q[4] + HALF) >>> (CBITS - OBITS));
            y_imag_d = OBITS'((ci_q[4] + HALF) >>> (CBITS - OBITS));
`else
            y_real_d = OBITS'(cr_q[4] >>> (CBITS - OBITS));
            y_imag_d = OBITS'(ci_q[4] >>> (CBITS - OBITS));
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 5; k++) begin
                ir_q[k] <= '0;
                ii_q[k] <= '0;
                cr_q[k] <= '0;
                ci_q[k] <= '0;
                dr_q[k] <= '0;
                di_q[k] <= '0;
            end
            cnt_q        <= '0;
            v_q          <= '0;
            out_strobe_q <= 1'b0;
            y_real_q     <= '0;
            y_imag_q     <= '0;
        end else begin
            ir_q         <= ir_d;
            ii_q         <= ii_d;
            cr_q         <= cr_d;
            ci_q         <= ci_d;
            dr_q         <= dr_d;
            di_q         <= di_d;
            cnt_q        <= cnt_d;
            v_q          <= v_d;
            out_strobe_q <= out_strobe_d;
            y_real_q     <= y_real_d;
            y_imag_q     <= y_imag_d;
        end
    end

    assign out_strobe = out_strobe_q;
    assign y_real     = y_real_q;
    assign y_imag     = y_imag_q;

endmodule

// File: tb/tb_cic_decim_m5.sv
// Self-checking bench for cic_decim_m5: scoreboard of expected outputs
// (value and arrival cycle) plus steady-state constants per scenario.
module tb_cic_decim_m5;

    localparam int CB = 43;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_strobe = 1'b0;
    logic signed [17:0] x_real = '0;
    logic signed [17:0] x_imag = '0;
    logic out_strobe;
    logic signed [23:0] y_real, y_imag;

    logic s2 = 1'b0;
    logic signed [17:0] x2r = '0;
    logic signed [17:0] x2i = '0;
    logic out2;
    logic signed [23:0] y2r, y2i;

    always #5 clk = ~clk;

    cic_decim_m5 dut (
        .clock(clk), .reset_n(rst_n), .in_strobe(in_strobe),
        .x_real(x_real), .x_imag(x_imag), .out_strobe(out_strobe),
        .y_real(y_real), .y_imag(y_imag)
    );

    cic_decim_m5 #(.RATE(20), .IBITS(18), .OBITS(24), .GBITS(22)) dut2 (
        .clock(clk), .reset_n(rst_n), .in_strobe(s2),
        .x_real(x2r), .x_imag(x2i), .out_strobe(out2),
        .y_real(y2r), .y_imag(y2i)
    );

    typedef struct {
        logic signed [23:0] re;
        logic signed [23:0] im;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int cyc = 0;
    int total = 0;
    int bad = 0;
    int n_out = 0;
    int n2 = 0;
    int last_cyc = 0;
    logic signed [23:0] last_re = '0;
    logic signed [23:0] last_im = '0;

    logic signed [CB-1:0] mr[5], mi[5], mdr[5], mdi[5];
    int mcnt = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (out2 === 1'b1) n2 = n2 + 1;

    function automatic logic signed [23:0] top(input logic signed [CB-1:0] c);
        logic signed [CB-1:0] t;
        t = c;
`ifdef CIC_DECIM_ROUND_EN
        t = t + (43'sd1 <<< 18);
`endif
        return t[CB-1 -: 24];
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 5; k++) begin
            mr[k] = '0; mi[k] = '0; mdr[k] = '0; mdi[k] = '0;
        end
        mcnt = 0;
        sb.delete();
    endtask

    task automatic model_strobe(input logic signed [17:0] xr,
                                input logic signed [17:0] xi);
        logic signed [CB-1:0] cr, ci, t;
        exp_t e;
        for (int k = 4; k > 0; k--) begin
            mr[k] = mr[k] + mr[k-1];
            mi[k] = mi[k] + mi[k-1];
        end
        mr[0] = mr[0] + {{25{xr[17]}}, xr};
        mi[0] = mi[0] + {{25{xi[17]}}, xi};
        if (mcnt == 31) begin
            mcnt = 0;
            cr = mr[4];
            ci = mi[4];
            for (int k = 0; k < 5; k++) begin
                t = cr - mdr[k]; mdr[k] = cr; cr = t;
                t = ci - mdi[k]; mdi[k] = ci; ci = t;
            end
            e.re = top(cr);
            e.im = top(ci);
            e.cyc = cyc + 7;
            sb.push_back(e);
        end else begin
            mcnt = mcnt + 1;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            total = total + 1; bad = bad + 1;
            $display("FAIL missing_out: none at cycle %0d, required one", sb[0].cyc);
            void'(sb.pop_front());
        end
        if (out_strobe === 1'b1) begin
            n_out = n_out + 1;
            last_re = y_real;
            last_im = y_imag;
            last_cyc = cyc;
            total = total + 1;
            if (sb.size() == 0) begin
                bad = bad + 1;
                $display("FAIL unexpected_out: strobe at cycle %0d, required none", cyc);
            end else begin
                e = sb.pop_front();
                if (cyc !== e.cyc) begin
                    bad = bad + 1;
                    $display("FAIL out_cycle: got %0d required %0d", cyc, e.cyc);
                end
                total = total + 1;
                if (y_real !== e.re) begin
                    bad = bad + 1;
                    $display("FAIL sb_real: got %0d required %0d", y_real, e.re);
                end
                total = total + 1;
                if (y_imag !== e.im) begin
                    bad = bad + 1;
                    $display("FAIL sb_imag: got %0d required %0d", y_imag, e.im);
                end
            end
        end
    end

    task automatic drive(input logic s, input logic signed [17:0] xr,
                         input logic signed [17:0] xi);
        @(posedge clk);
        #1;
        in_strobe = s;
        x_real = xr;
        x_imag = xi;
        if (s && rst_n) model_strobe(xr, xi);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_clear();
        idle(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int s32;
        int n0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_clear();
        for (int i = 0; i < 8; i++) begin
            drive(1'($urandom_range(0, 1)), 18'($urandom), 18'($urandom));
            @(negedge clk);
            total = total + 1;
            if (out_strobe !== 1'b0 || y_real !== 24'sd0 || y_imag !== 24'sd0) begin
                bad = bad + 1;
                $display("FAIL reset_hold: got %b/%0d/%0d required 0/0/0",
                         out_strobe, y_real, y_imag);
            end
        end
        idle(1);
        rst_n = 1'b1;
        n0 = n_out;
        for (int i = 0; i < 32; i++) drive(1'b1, 18'sd1000, -18'sd1000);
        s32 = cyc + 1;
        idle(10);
        total = total + 1;
        if (n_out - n0 !== 1) begin
            bad = bad + 1;
            $display("FAIL reset_first_count: got %0d required 1", n_out - n0);
        end
        total = total + 1;
        if (last_cyc - s32 !== 6) begin
            bad = bad + 1;
            $display("FAIL reset_first_latency: got %0d required 6", last_cyc - s32);
        end
    endtask

    task automatic test_dc();
        int n0;
        do_reset();
        n0 = n_out;
        for (int i = 0; i < 320; i++) drive(1'b1, 18'sd1000, -18'sd1000);
        idle(10);
        total = total + 1;
        if (n_out - n0 !== 10) begin
            bad = bad + 1;
            $display("FAIL dc_count: got %0d required 10", n_out - n0);
        end
        total = total + 1;
        if (last_re !== 24'sd64000 || last_im !== -24'sd64000) begin
            bad = bad + 1;
            $display("FAIL dc_steady: got %0d/%0d required 64000/-64000",
                     last_re, last_im);
        end
    endtask

    task automatic test_full_scale();
        int n0;
        do_reset();
        n0 = n_out;
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, -18'sd131072, 18'sd131071);
            idle(2);
        end
        idle(10);
        total = total + 1;
        if (n_out - n0 !== 8) begin
            bad = bad + 1;
            $display("FAIL fs_count: got %0d required 8", n_out - n0);
        end
        total = total + 1;
        if (last_re !== -24'sd8388608 || last_im !== 24'sd8388544) begin
            bad = bad + 1;
            $display("FAIL fs_steady: got %0d/%0d required -8388608/8388544",
                     last_re, last_im);
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        int s32;
        do_reset();
        for (int i = 0; i < 32; i++) drive(1'b1, 18'sd1000, -18'sd1000);
        idle(2);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_clear();
        n0 = n_out;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total = total + 1;
            if (out_strobe !== 1'b0 || y_real !== 24'sd0 || y_imag !== 24'sd0) begin
                bad = bad + 1;
                $display("FAIL mid_reset_out: got %b/%0d/%0d required 0/0/0",
                         out_strobe, y_real, y_imag);
            end
        end
        idle(1);
        rst_n = 1'b1;
        idle(10);
        total = total + 1;
        if (n_out !== n0) begin
            bad = bad + 1;
            $display("FAIL mid_discard: got %0d outputs required 0", n_out - n0);
        end
        for (int i = 0; i < 32; i++) drive(1'b1, 18'sd1000, -18'sd1000);
        s32 = cyc + 1;
        idle(10);
        total = total + 1;
        if (n_out - n0 !== 1 || last_cyc - s32 !== 6) begin
            bad = bad + 1;
            $display("FAIL mid_restart: got n=%0d lat=%0d required n=1 lat=6",
                     n_out - n0, last_cyc - s32);
        end
    endtask

    task automatic test_gaps();
        int n0;
        do_reset();
        n0 = n_out;
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 18'sd1000, -18'sd1000);
            idle($urandom_range(0, 5));
        end
        idle(10);
        total = total + 1;
        if (n_out - n0 !== 8) begin
            bad = bad + 1;
            $display("FAIL gap_count: got %0d required 8", n_out - n0);
        end
        total = total + 1;
        if (last_re !== 24'sd64000 || last_im !== -24'sd64000) begin
            bad = bad + 1;
            $display("FAIL gap_steady: got %0d/%0d required 64000/-64000",
                     last_re, last_im);
        end
    endtask

    task automatic test_rounding();
        int n0;
        logic signed [23:0] exp_y;
`ifdef CIC_DECIM_ROUND_EN
        exp_y = 24'sd49;
`else
        exp_y = 24'sd48;
`endif
        do_reset();
        n0 = n2;
        for (int i = 0; i < 160; i++) begin
            @(posedge clk);
            #1;
            s2 = 1'b1; x2r = 18'sd1; x2i = 18'sd1;
        end
        @(posedge clk);
        #1;
        s2 = 1'b0; x2r = '0; x2i = '0;
        idle(10);
        total = total + 1;
        if (n2 - n0 !== 8) begin
            bad = bad + 1;
            $display("FAIL round_count: got %0d required 8", n2 - n0);
        end
        total = total + 1;
        if (y2r !== exp_y || y2i !== exp_y) begin
            bad = bad + 1;
            $display("FAIL round_steady: got %0d/%0d required %0d",
                     y2r, y2i, exp_y);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_dc();
        test_full_scale();
        test_reset_mid();
        test_gaps();
        test_rounding();
        total = total + 1;
        if (sb.size() !== 0) begin
            bad = bad + 1;
            $display("FAIL sb_drain: got %0d pending required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
